// File: rtl/cnn_layer_scheduler.sv
// Sequencer for the CNN layer chain: overlapped layer begin pulses, ping-pong
// bank select, per-layer watchdog and frame accounting for the host FSM.
module cnn_layer_scheduler #(
    parameter int          NUM_LAYERS = 8,
    parameter int unsigned TIMEOUT    = 50000,
    parameter int          CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_LAYERS-1:0] layer_done,
    output logic [NUM_LAYERS-1:0] layer_begin,
    output logic                  bank_sel,
    output logic [3:0]            cur_layer,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  error,
    output logic [7:0]            frame_cnt
);
    // state   | meaning
    // IDLE    | waiting for start
    // LAUNCH  | begin pulses for layers 0 and 1
    // RUN     | waiting for completion edge of cur_layer, watchdog counting
    // ADVANCE | step to next layer, flip bank, arm layer cur_layer+2
    // DONE    | frame complete
    // ERR     | watchdog expired
    typedef enum logic [2:0] {IDLE, LAUNCH, RUN, ADVANCE, DONE, ERR} state_t;

    localparam logic [3:0]            LAST        = 4'(NUM_LAYERS - 1);
    localparam logic [NUM_LAYERS-1:0] LAUNCH_MASK = NUM_LAYERS'(3);
    localparam logic [CNT_W-1:0]      WD_LIMIT    = CNT_W'(TIMEOUT - 1);

    state_t                state;
    logic [NUM_LAYERS-1:0] done_q;
    logic [NUM_LAYERS-1:0] cur_mask;
    logic [NUM_LAYERS-1:0] arm_mask;
    logic [CNT_W-1:0]      wdog;
    logic [4:0]            arm_idx;
    logic                  cur_edge;

    assign arm_idx = {1'b0, cur_layer} + 5'd2;

    // Indices past the last layer simply produce an empty arm mask.
    always_comb begin
        cur_mask = '0;
        arm_mask = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            cur_mask[i] = (4'(i) == cur_layer);
            arm_mask[i] = (5'(i) == arm_idx);
        end
    end

    assign cur_edge = |(layer_done & ~done_q & cur_mask);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            layer_begin <= '0;
            bank_sel    <= 1'b0;
            cur_layer   <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            error       <= 1'b0;
            frame_cnt   <= '0;
            done_q      <= '0;
            wdog        <= '0;
        end else begin
            done_q      <= layer_done;
            layer_begin <= '0;
            frame_done  <= 1'b0;
            if (abort && state != IDLE) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state       <= LAUNCH;
                            cur_layer   <= '0;
                            bank_sel    <= 1'b0;
                            error       <= 1'b0;
                            busy        <= 1'b1;
                            layer_begin <= LAUNCH_MASK;
                        end
                    end
                    LAUNCH: begin
                        wdog  <= '0;
                        state <= RUN;
                    end
                    RUN: begin
                        if (wdog != '1)
                            wdog <= wdog + CNT_W'(1);
                        // A completion edge seen on the last watchdog cycle still counts.
                        if (cur_edge) begin
                            state <= (cur_layer == LAST) ? DONE : ADVANCE;
                        end else if (wdog == WD_LIMIT) begin
                            state <= ERR;
                            error <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                    ADVANCE: begin
                        cur_layer   <= cur_layer + 4'd1;
                        bank_sel    <= ~bank_sel;
                        wdog        <= '0;
                        layer_begin <= arm_mask;
                        state       <= RUN;
                    end
                    DONE: begin
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 8'd1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                    ERR: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cnn_layer_scheduler.sv
// Scoreboard bench: a cycle-scheduled layer model drives layer_done and predicts
// every visible output change; a monitor pops and compares on each change.
`timescale 1ns/1ps
module tb_cnn_layer_scheduler;
    localparam int N   = 8;
    localparam int TMO = 100;
    localparam int M_NOM = 0, M_RND = 1, M_TMO = 2, M_ABT = 3, M_RST = 4, M_SPUR = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [N-1:0] layer_done = '0;
    logic [N-1:0] layer_begin;
    logic         bank_sel, busy, frame_done, error;
    logic [3:0]   cur_layer;
    logic [7:0]   frame_cnt;

    cnn_layer_scheduler #(.NUM_LAYERS(N), .TIMEOUT(TMO), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .layer_done(layer_done), .layer_begin(layer_begin), .bank_sel(bank_sel),
        .cur_layer(cur_layer), .busy(busy), .frame_done(frame_done),
        .error(error), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int           cyc;
        logic [N-1:0] beg;
        logic         fd;
        logic         err;
        logic         bank;
        logic [3:0]   cur;
        logic         busy;
        logic [7:0]   cnt;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad = 0;

    logic       m_bank = 1'b0, m_err = 1'b0, m_busy = 1'b0;
    logic [3:0] m_cur = '0;
    logic [7:0] m_cnt = '0;
    logic       mon_en = 1'b0;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic expect_ev(input int at, input logic [N-1:0] beg, input logic fd);
        ev_t e;
        e.cyc = at; e.beg = beg; e.fd = fd; e.err = m_err; e.bank = m_bank;
        e.cur = m_cur; e.busy = m_busy; e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    // Any begin pulse, frame_done pulse or change of a status output is an event.
    logic [14:0] prev_st = '0;
    always @(negedge clk) begin : monitor
        logic [14:0] st;
        ev_t a, e;
        st = {error, bank_sel, cur_layer, busy, frame_cnt};
        if (mon_en && (layer_begin != '0 || frame_done || st != prev_st)) begin
            a.cyc = cyc; a.beg = layer_begin; a.fd = frame_done; a.err = error;
            a.bank = bank_sel; a.cur = cur_layer; a.busy = busy; a.cnt = frame_cnt;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event cyc=%0d got beg=%b fd=%b err=%b bank=%b cur=%0d busy=%b cnt=%0d, required no event",
                         a.cyc, a.beg, a.fd, a.err, a.bank, a.cur, a.busy, a.cnt);
            end else begin
                e = exp_q.pop_front();
                if (a != e) begin
                    bad++;
                    $display("FAIL event got cyc=%0d beg=%b fd=%b err=%b bank=%b cur=%0d busy=%b cnt=%0d, required cyc=%0d beg=%b fd=%b err=%b bank=%b cur=%0d busy=%b cnt=%0d",
                             a.cyc, a.beg, a.fd, a.err, a.bank, a.cur, a.busy, a.cnt,
                             e.cyc, e.beg, e.fd, e.err, e.bank, e.cur, e.busy, e.cnt);
                end
            end
        end
        prev_st = st;
    end

    task automatic run_frame(input int mode, input int sk, input bit hold, input logic [N-1:0] keep);
        int s, r, t, j, dly;
        s = cyc;
        start = 1'b1;
        layer_done = layer_done & keep;
        m_err = 1'b0; m_bank = 1'b0; m_cur = '0; m_busy = 1'b1;
        expect_ev(s + 1, N'(3), 1'b0);
        step();
        if (!hold) start = 1'b0;
        r = s + 2;
        for (int k = 0; k < N; k++) begin
            while (cyc < r) step();
            if (mode == M_TMO && k == sk) begin
                m_err = 1'b1; m_busy = 1'b0;
                expect_ev(r + TMO, '0, 1'b0);
                while (cyc < r + TMO + 1) step();
                return;
            end
            if (mode == M_RST && k == sk) begin
                repeat ($urandom_range(3, 0)) step();
                rst = 1'b0;
                layer_done = '0;
                m_err = 1'b0; m_bank = 1'b0; m_cur = '0; m_busy = 1'b0; m_cnt = '0;
                expect_ev(cyc + 1, '0, 1'b0);
                step();
                rst = 1'b1;
                step();
                return;
            end
            // A level left high must fall and rise again to count.
            if (layer_done[k]) begin
                repeat ($urandom_range(2, 0)) step();
                layer_done[k] = 1'b0;
                step();
            end
            j = -1;
            if (mode == M_SPUR && k == 2) j = 6;
            else if (mode != M_NOM && k < N - 1 && $urandom_range(3, 0) == 0)
                j = int'($urandom_range(N - 1, k + 1));
            if (j >= 0 && !layer_done[j]) begin
                layer_done[j] = 1'b1;
                step();
                layer_done[j] = 1'b0;
                step();
            end
            dly = (mode == M_NOM) ? 20 : int'($urandom_range(5, 0));
            repeat (dly) step();
            t = cyc;
            layer_done[k] = 1'b1;
            if (mode == M_ABT && k == sk) begin
                abort = 1'b1;
                m_busy = 1'b0;
                expect_ev(t + 1, '0, 1'b0);
                step();
                abort = 1'b0;
                return;
            end
            if (k < N - 1) begin
                m_cur = 4'(k + 1);
                m_bank = ~m_bank;
                expect_ev(t + 2, (k + 2 < N) ? (N'(1) << (k + 2)) : '0, 1'b0);
                r = t + 2;
                step();
            end else begin
                m_busy = 1'b0;
                m_cnt = m_cnt + 8'd1;
                expect_ev(t + 2, '0, 1'b1);
                while (cyc < t + 2) step();
            end
        end
    endtask

    initial begin
        int mode;
        bit hold;
        repeat (3) step();
        total++;
        if ({layer_begin, bank_sel, cur_layer, busy, frame_done, error, frame_cnt} != '0) begin
            bad++;
            $display("FAIL reset_state got=%h required=0",
                     {layer_begin, bank_sel, cur_layer, busy, frame_done, error, frame_cnt});
        end
        rst = 1'b1;
        step();
        mon_en = 1'b1;
        step();

        run_frame(M_NOM, 0, 1'b0, '0);   step(); step();
        run_frame(M_TMO, 3, 1'b0, '0);   step(); step();
        run_frame(M_NOM, 0, 1'b0, '0);   step();
        run_frame(M_ABT, 5, 1'b0, '0);   step();
        run_frame(M_RND, 0, 1'b0, '0);   step();
        run_frame(M_SPUR, 0, 1'b0, N'(4)); step();
        run_frame(M_RND, 0, 1'b1, '0);
        run_frame(M_RND, 0, 1'b1, '0);
        run_frame(M_RND, 0, 1'b0, '0);   step();
        run_frame(M_RST, 4, 1'b0, '0);   step();
        run_frame(M_NOM, 0, 1'b0, '0);   step();

        for (int f = 0; f < 300; f++) begin
            mode = ($urandom_range(19, 0) == 0) ? M_ABT : M_RND;
            hold = (mode == M_RND && f != 299 && $urandom_range(3, 0) == 0);
            run_frame(mode, int'($urandom_range(N - 1, 0)), hold, N'($urandom() & $urandom() & $urandom()));
            if (!hold) repeat ($urandom_range(2, 0)) step();
        end

        repeat (5) step();
        @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_events got=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
